mult_sweep_checker: RTL and testbench

- Self-checking stimulus/response stage for the combinational 4x4 unsigned multiplier `multiplicador`.
- Sweeps all 256 operand pairs into the multiplier's a..h inputs and samples its o0..o7 product.
- Compares each product against an internal sequential shift-add reference, then reports the mismatch count and the first failing pair.
- Lets the multiplier be verified exhaustively in silicon or synthesis-level simulation without a behavioural `*` in the testbench.

---
 rtl/mult_sweep_checker.sv | 193 +++++++++++++++++++
 tb/tb_mult_sweep_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sweep_checker.sv
// Exhaustive 4x4 multiplier checker: drives all 256 operand pairs, builds a shift-add
// reference product for each pair and tallies mismatches against the observed product.
module mult_sweep_checker #(
  parameter int SETTLE_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  input  logic [7:0] prod_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_count,
  output logic       first_err_valid,
  output logic [3:0] first_err_a,
  output logic [3:0] first_err_b,
  output logic [7:0] first_err_prod
);

  localparam int DATA_W = 4;
  localparam logic [3:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [7:0]        acc_q, acc_d;
  logic [7:0]        mcand_q, mcand_d;
  logic [3:0]        mplier_q, mplier_d;
  logic [1:0]        step_q, step_d;
  logic [3:0]        settle_q, settle_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [8:0]        err_q, err_d;
  logic              fe_valid_q, fe_valid_d;
  logic [3:0]        fe_a_q, fe_a_d;
  logic [3:0]        fe_b_q, fe_b_d;
  logic [7:0]        fe_prod_q, fe_prod_d;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    step_d     = step_q;
    settle_d   = settle_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    fe_valid_d = fe_valid_q;
    fe_a_d     = fe_a_q;
    fe_b_d     = fe_b_q;
    fe_prod_d  = fe_prod_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_LOAD;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          err_d      = 9'd0;
          fe_valid_d = 1'b0;
          fe_a_d     = 4'd0;
          fe_b_d     = 4'd0;
          fe_prod_d  = 8'd0;
          idx_d      = 8'd0;
        end
      end

      S_LOAD: begin
        // Operands only ever change here, so the multiplier sees them stable until CHECK.
        op_a_d   = idx_q[7:4];
        op_b_d   = idx_q[3:0];
        acc_d    = 8'd0;
        mcand_d  = {4'b0000, idx_q[7:4]};
        mplier_d = idx_q[3:0];
        step_d   = 2'd0;
        state_d  = S_CALC;
      end

      S_CALC: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + 2'd1;
        if (step_q == 2'd3) begin
          if (SETTLE_CYCLES > 0) begin
            settle_d = 4'd0;
            state_d  = S_SETTLE;
          end else begin
            state_d = S_CHECK;
          end
        end
      end

      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end

      S_CHECK: begin
        if (prod_in != acc_q) begin
          err_d = err_q + 9'd1;
          if (!fe_valid_q) begin
            fe_valid_d = 1'b1;
            fe_a_d     = op_a_q;
            fe_b_d     = op_b_q;
            fe_prod_d  = prod_in;
          end
        end
        if (idx_q == 8'hFF) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_LOAD;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      step_q     <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= '0;
      fe_valid_q <= 1'b0;
      fe_a_q     <= '0;
      fe_b_q     <= '0;
      fe_prod_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      step_q     <= step_d;
      settle_q   <= settle_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      fe_valid_q <= fe_valid_d;
      fe_a_q     <= fe_a_d;
      fe_b_q     <= fe_b_d;
      fe_prod_q  <= fe_prod_d;
    end
  end

  assign op_a            = op_a_q;
  assign op_b            = op_b_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = done_q && (err_q == 9'd0);
  assign err_count       = err_q;
  assign first_err_valid = fe_valid_q;
  assign first_err_a     = fe_a_q;
  assign first_err_b     = fe_b_q;
  assign first_err_prod  = fe_prod_q;

endmodule

// File: tb/tb_mult_sweep_checker.sv
// Bench for mult_sweep_checker: two instances (SETTLE_CYCLES 0 and 2) share a faultable
// multiplier model; expected sweep results are queued at start and popped when done rises.
module tb_mult_sweep_checker;

  typedef struct {
    int errs;
    int fv;
    int fa;
    int fb;
    int fp;
    int lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [7:0] am = 8'hFF;
  logic [7:0] om = 8'h00;
  logic [7:0] xm = 8'h00;

  logic [3:0] op_a0, op_b0, fa0, fb0, op_a1, op_b1, fa1, fb1;
  logic [7:0] prod0, prod1, fp0, fp1, full0, full1;
  logic       busy0, done0, pass0, fev0, busy1, done1, pass1, fev1;
  logic [8:0] err0, err1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign full0 = 8'({4'b0000, op_a0} * {4'b0000, op_b0});
  assign full1 = 8'({4'b0000, op_a1} * {4'b0000, op_b1});
  assign prod0 = ((full0 & am) | om) ^ xm;
  assign prod1 = ((full1 & am) | om) ^ xm;

  mult_sweep_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a0), .op_b(op_b0), .prod_in(prod0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_valid(fev0),
    .first_err_a(fa0), .first_err_b(fb0), .first_err_prod(fp0)
  );

  mult_sweep_checker #(.SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a1), .op_b(op_b1), .prod_in(prod1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_valid(fev1),
    .first_err_a(fa1), .first_err_b(fb1), .first_err_prod(fp1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: walk every pair with plain arithmetic and the same output fault.
  function automatic exp_t model(input int settle, input int a_m, input int o_m, input int x_m);
    exp_t e;
    int p, obs;
    e.errs = 0; e.fv = 0; e.fa = 0; e.fb = 0; e.fp = 0;
    e.lat = 256 * (6 + settle);
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        p = a * b;
        obs = (((p & a_m) | o_m) ^ x_m) & 255;
        if (obs != p) begin
          e.errs++;
          if (e.fv == 0) begin
            e.fv = 1; e.fa = a; e.fb = b; e.fp = obs;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic check_result(input string tag, input exp_t e, input int lat, input logic busy,
                              input logic pass, input logic [8:0] ec, input logic fev,
                              input logic [3:0] fa, input logic [3:0] fb, input logic [7:0] fp);
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_busy_low"}, busy, 0);
    chk({tag, "_err_count"}, ec, e.errs);
    chk({tag, "_pass"}, pass, (e.errs == 0));
    chk({tag, "_first_valid"}, fev, e.fv);
    if (e.fv != 0) begin
      chk({tag, "_first_a"}, fa, e.fa);
      chk({tag, "_first_b"}, fb, e.fb);
      chk({tag, "_first_prod"}, fp, e.fp);
    end
  endtask

  logic busy0_prev = 1'b0, done0_prev = 1'b0, busy1_prev = 1'b0, done1_prev = 1'b0;
  int rise0 = 0, rise1 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (busy0 && !busy0_prev) rise0 = cyc;
    if (done0 && !done0_prev) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL s0_unexpected_done: done rose with no expected sweep queued");
      end else begin
        e = q0.pop_front();
        check_result("s0", e, cyc - rise0, busy0, pass0, err0, fev0, fa0, fb0, fp0);
      end
    end
    busy0_prev = busy0;
    done0_prev = done0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (busy1 && !busy1_prev) rise1 = cyc;
    if (done1 && !done1_prev) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL s2_unexpected_done: done rose with no expected sweep queued");
      end else begin
        e = q1.pop_front();
        check_result("s2", e, cyc - rise1, busy1, pass1, err1, fev1, fa1, fb1, fp1);
      end
    end
    busy1_prev = busy1;
    done1_prev = done1;
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic issue();
    q0.push_back(model(0, am, om, xm));
    q1.push_back(model(2, am, om, xm));
    pulse_start();
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(done0 && done1) && n < 2300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2300) begin
      checks++; errors++;
      $display("FAIL %s_timeout: done0=%0b done1=%0b after %0d cycles", tag, done0, done1, n);
    end
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_s0_outputs"}, {op_a0, op_b0, busy0, done0, pass0, err0, fev0, fa0, fb0, fp0}, 0);
    chk({tag, "_s2_outputs"}, {op_a1, op_b1, busy1, done1, pass1, err1, fev1, fa1, fb1, fp1}, 0);
  endtask

  task automatic set_masks(input logic [7:0] a_m, input logic [7:0] o_m, input logic [7:0] x_m);
    am = a_m; om = o_m; xm = x_m;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // Golden sweep with a start re-pulse while busy.
    set_masks(8'hFF, 8'h00, 8'h00);
    issue();
    repeat (48) @(negedge clk);
    pulse_start();
    wait_done("golden");

    // o0 stuck-at-0, then an immediate restart from DONE with the golden model.
    set_masks(8'h7F, 8'h00, 8'h00);
    issue();
    wait_done("stuck0_o0");
    set_masks(8'hFF, 8'h00, 8'h00);
    issue();
    chk("restart_s0_cleared", {busy0, done0, err0, fev0}, {1'b1, 1'b0, 9'd0, 1'b0});
    chk("restart_s2_cleared", {busy1, done1, err1, fev1}, {1'b1, 1'b0, 9'd0, 1'b0});
    wait_done("restart_golden");

    // o7 stuck-at-1.
    set_masks(8'hFF, 8'h01, 8'h00);
    issue();
    wait_done("stuck1_o7");

    // Reset 100 cycles into a sweep, start held high alongside it.
    set_masks(8'hFF, 8'h00, 8'h00);
    issue();
    repeat (99) @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    q0.delete();
    q1.delete();
    check_zero("midsweep_reset");
    @(negedge clk);
    check_zero("after_reset_idle");
    issue();
    wait_done("post_reset_golden");

    // Randomized output faults.
    for (int k = 0; k < 4; k++) begin
      int mode;
      logic [7:0] bitm;
      mode = $urandom_range(3);
      bitm = 8'(1) << $urandom_range(7);
      case (mode)
        0: set_masks(~bitm, 8'h00, 8'h00);
        1: set_masks(8'hFF, bitm, 8'h00);
        2: set_masks(8'hFF, 8'h00, bitm);
        default: set_masks(8'($urandom) | 8'($urandom), 8'($urandom) & 8'($urandom), 8'h00);
      endcase
      issue();
      wait_done("random");
    end

    chk("s0_queue_drained", q0.size(), 0);
    chk("s2_queue_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
